// File: rtl/neuromorphic_x1_wb_master_if.sv
// Command/response and Wishbone signal bundle for the X1 Wishbone master.
// The master modport is the bridge's own view; the slave modport is the environment side.
interface neuromorphic_x1_wb_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i,
    input  rsp_ready_i,
    input  wbm_dat_i, wbm_ack_i,
    output req_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i,
    output rsp_ready_i,
    output wbm_dat_i, wbm_ack_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/neuromorphic_x1_wb_master.sv
// Single-outstanding command-to-Wishbone bridge for the X1 slave.
// A request becomes one cyc/stb burst that ends on ack or after TIMEOUT_CYC wait cycles.
module neuromorphic_x1_wb_master #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                          wb_clk_i,
  input logic                          wb_rst_n_i,
  neuromorphic_x1_wb_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter holds the number of BUS cycles already spent without ack.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [15:0] wait_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values of the registers it tests.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.req_ready_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.wbm_cyc_o   <= 1'b0;
      bus.wbm_stb_o   <= 1'b0;
      bus.wbm_we_o    <= 1'b0;
      bus.wbm_sel_o   <= 4'h0;
      bus.wbm_adr_o   <= '0;
      bus.wbm_dat_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Ready comes up one edge after reset release or after a response handshake.
          bus.req_ready_o <= 1'b1;
          if (bus.req_ready_o && bus.req_valid_i) begin
            state           <= BUS;
            wait_cnt        <= '0;
            bus.req_ready_o <= 1'b0;
            bus.wbm_cyc_o   <= 1'b1;
            bus.wbm_stb_o   <= 1'b1;
            bus.wbm_sel_o   <= 4'hF;
            bus.wbm_we_o    <= bus.req_we_i;
            bus.wbm_adr_o   <= bus.req_adr_i;
            bus.wbm_dat_o   <= bus.req_dat_i;
          end
        end

        BUS: begin
          if (bus.wbm_ack_i) begin
            // Ack is tested first so it wins over an expiry on the same edge.
            state           <= RESP;
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_sel_o   <= 4'h0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_dat_o   <= bus.wbm_we_o ? 32'h0 : bus.wbm_dat_i;
          end else if (wait_cnt == CNT_LAST) begin
            state           <= RESP;
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_sel_o   <= 4'h0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_dat_o   <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready_i) begin
            state           <= IDLE;
            bus.rsp_valid_o <= 1'b0;
            bus.req_ready_o <= 1'b1;
          end
        end

        default: begin
          state           <= IDLE;
          bus.req_ready_o <= 1'b0;
          bus.rsp_valid_o <= 1'b0;
          bus.wbm_cyc_o   <= 1'b0;
          bus.wbm_stb_o   <= 1'b0;
          bus.wbm_sel_o   <= 4'h0;
        end
      endcase
    end
  end

  // Structural invariants of the bridge.
  a_cyc_eq_stb : assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    bus.wbm_cyc_o == bus.wbm_stb_o);

  a_sel_follows_stb : assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    bus.wbm_sel_o == (bus.wbm_stb_o ? 4'hF : 4'h0));

  a_single_outstanding : assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    bus.req_ready_o |-> !(bus.wbm_stb_o || bus.rsp_valid_o));

  a_bus_fields_stable : assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    (bus.wbm_stb_o && $past(bus.wbm_stb_o)) |->
      ($stable(bus.wbm_we_o) && $stable(bus.wbm_adr_o) && $stable(bus.wbm_dat_o)));

  a_rsp_stable : assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    (bus.rsp_valid_o && $past(bus.rsp_valid_o)) |->
      ($stable(bus.rsp_dat_o) && $stable(bus.rsp_err_o)));

endmodule

// File: tb/tb_neuromorphic_x1_wb_master.sv
// Directed bench for neuromorphic_x1_wb_master: main instance with an 8-cycle timeout,
// second instance with a 4-cycle timeout for the ack-on-expiry boundary.
module tb_neuromorphic_x1_wb_master;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  neuromorphic_x1_wb_master_if bus8 ();
  neuromorphic_x1_wb_master_if bus4 ();

  neuromorphic_x1_wb_master #(.TIMEOUT_CYC(8)) u_dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus8)
  );

  neuromorphic_x1_wb_master #(.TIMEOUT_CYC(4)) u_dut4 (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus8.req_valid_i = 1'b1;
    bus8.req_we_i    = we;
    bus8.req_adr_i   = adr;
    bus8.req_dat_i   = dat;
    tick;
    bus8.req_valid_i = 1'b0;
  endtask

  task automatic handshake;
    bus8.rsp_ready_i = 1'b1;
    tick;
    bus8.rsp_ready_i = 1'b0;
  endtask

  // Plays the slave for one burst; ack_at=k acks at the k-th edge after acceptance (0 = never).
  task automatic bus_phase(input int ack_at, input logic [31:0] rdata, input logic exp_we,
                           input logic [31:0] exp_adr, input logic [31:0] exp_dat,
                           output int stb_cnt, output bit fields_ok);
    stb_cnt   = 0;
    fields_ok = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      if (bus8.wbm_stb_o !== 1'b1) break;
      stb_cnt++;
      if (bus8.wbm_cyc_o !== 1'b1 || bus8.wbm_sel_o !== 4'hF || bus8.wbm_we_o !== exp_we ||
          bus8.wbm_adr_o !== exp_adr || bus8.wbm_dat_o !== exp_dat)
        fields_ok = 1'b0;
      if (i == ack_at) begin
        bus8.wbm_ack_i = 1'b1;
        bus8.wbm_dat_i = rdata;
      end
      tick;
      bus8.wbm_ack_i = 1'b0;
      bus8.wbm_dat_i = 32'h5A5A_0F0F;
    end
  endtask

  task automatic test_reset;
    {bus8.req_valid_i, bus8.req_we_i, bus8.rsp_ready_i, bus8.wbm_ack_i} = '0;
    {bus8.req_adr_i, bus8.req_dat_i, bus8.wbm_dat_i} = '0;
    {bus4.req_valid_i, bus4.req_we_i, bus4.rsp_ready_i, bus4.wbm_ack_i} = '0;
    {bus4.req_adr_i, bus4.req_dat_i, bus4.wbm_dat_i} = '0;
    #1 rst_n = 1'b0;
    #6;
    tests++;
    if ({bus8.wbm_cyc_o, bus8.wbm_stb_o, bus8.wbm_we_o, bus8.wbm_sel_o, bus8.rsp_valid_o,
         bus8.rsp_err_o, bus8.req_ready_o} !== 10'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b sel=%h rv=%b err=%b rdy=%b want all 0",
               bus8.wbm_cyc_o, bus8.wbm_stb_o, bus8.wbm_we_o, bus8.wbm_sel_o,
               bus8.rsp_valid_o, bus8.rsp_err_o, bus8.req_ready_o);
    end
    tests++;
    if ({bus8.wbm_adr_o, bus8.wbm_dat_o, bus8.rsp_dat_o} !== 96'b0) begin
      fails++;
      $display("FAIL reset_data: got adr=%h dat=%h rsp_dat=%h want 0",
               bus8.wbm_adr_o, bus8.wbm_dat_o, bus8.rsp_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus8.req_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: got %b want 0", bus8.req_ready_o);
    end
    tick;
    tests++;
    if (bus8.req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_release: got %b want 1", bus8.req_ready_o);
    end
  endtask

  task automatic test_write;
    int n;
    bit ok;
    tests++;
    if (bus8.req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL write_ready: got %b want 1", bus8.req_ready_o);
    end
    issue_req(1'b1, 32'h3000_0004, 32'hA5A5_5A5A);
    bus_phase(2, 32'hFFFF_FFFF, 1'b1, 32'h3000_0004, 32'hA5A5_5A5A, n, ok);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL write_stb_cycles: got %0d want 2", n);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL write_bus_fields: got mismatching cyc/sel/we/adr/dat want 1/F/1/30000004/a5a55a5a");
    end
    tests++;
    if ({bus8.rsp_valid_o, bus8.rsp_err_o} !== 2'b10) begin
      fails++;
      $display("FAIL write_rsp_flags: got valid=%b err=%b want 1 0", bus8.rsp_valid_o, bus8.rsp_err_o);
    end
    tests++;
    if (bus8.rsp_dat_o !== 32'h0) begin
      fails++;
      $display("FAIL write_rsp_dat: got %h want 00000000", bus8.rsp_dat_o);
    end
    handshake;
    tests++;
    if ({bus8.rsp_valid_o, bus8.req_ready_o} !== 2'b01) begin
      fails++;
      $display("FAIL write_rsp_release: got valid=%b ready=%b want 0 1", bus8.rsp_valid_o, bus8.req_ready_o);
    end
  endtask

  task automatic test_read;
    int n;
    bit ok;
    issue_req(1'b0, 32'h3000_0010, 32'h0000_0000);
    bus_phase(5, 32'h1234_5678, 1'b0, 32'h3000_0010, 32'h0000_0000, n, ok);
    tests++;
    if (n !== 5 || !ok) begin
      fails++;
      $display("FAIL read_stb_cycles: got %0d fields_ok=%b want 5 1", n, ok);
    end
    tests++;
    if ({bus8.wbm_cyc_o, bus8.wbm_stb_o, bus8.rsp_valid_o, bus8.rsp_err_o} !== 4'b0010) begin
      fails++;
      $display("FAIL read_after_ack: got cyc=%b stb=%b valid=%b err=%b want 0 0 1 0",
               bus8.wbm_cyc_o, bus8.wbm_stb_o, bus8.rsp_valid_o, bus8.rsp_err_o);
    end
    tests++;
    if (bus8.rsp_dat_o !== 32'h1234_5678) begin
      fails++;
      $display("FAIL read_rsp_dat: got %h want 12345678", bus8.rsp_dat_o);
    end
    handshake;
  endtask

  task automatic test_timeout;
    int n;
    bit ok;
    issue_req(1'b0, 32'h3000_0020, 32'h0000_0000);
    bus_phase(0, 32'h0, 1'b0, 32'h3000_0020, 32'h0000_0000, n, ok);
    tests++;
    if (n !== 8 || !ok) begin
      fails++;
      $display("FAIL timeout_stb_cycles: got %0d fields_ok=%b want 8 1", n, ok);
    end
    tests++;
    if ({bus8.rsp_valid_o, bus8.rsp_err_o} !== 2'b11 || bus8.rsp_dat_o !== 32'h0) begin
      fails++;
      $display("FAIL timeout_rsp: got valid=%b err=%b dat=%h want 1 1 00000000",
               bus8.rsp_valid_o, bus8.rsp_err_o, bus8.rsp_dat_o);
    end
    bus8.wbm_ack_i = 1'b1;
    bus8.wbm_dat_i = 32'hDEAD_BEEF;
    tick;
    tick;
    bus8.wbm_ack_i = 1'b0;
    tests++;
    if ({bus8.rsp_valid_o, bus8.rsp_err_o, bus8.wbm_stb_o, bus8.wbm_cyc_o} !== 4'b1100 ||
        bus8.rsp_dat_o !== 32'h0) begin
      fails++;
      $display("FAIL spurious_ack_resp: got valid=%b err=%b stb=%b dat=%h want 1 1 0 00000000",
               bus8.rsp_valid_o, bus8.rsp_err_o, bus8.wbm_stb_o, bus8.rsp_dat_o);
    end
    handshake;
    bus8.wbm_ack_i = 1'b1;
    tick;
    tick;
    bus8.wbm_ack_i = 1'b0;
    tests++;
    if ({bus8.wbm_stb_o, bus8.wbm_cyc_o, bus8.rsp_valid_o, bus8.req_ready_o} !== 4'b0001) begin
      fails++;
      $display("FAIL spurious_ack_idle: got stb=%b cyc=%b valid=%b ready=%b want 0 0 0 1",
               bus8.wbm_stb_o, bus8.wbm_cyc_o, bus8.rsp_valid_o, bus8.req_ready_o);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    bit hold_ok;
    issue_req(1'b1, 32'h3000_0100, 32'h1111_1111);
    // Next request is presented immediately and held through BUS and RESP.
    bus8.req_valid_i = 1'b1;
    bus8.req_we_i    = 1'b0;
    bus8.req_adr_i   = 32'h3000_0200;
    bus8.req_dat_i   = 32'h2222_2222;
    bus_phase(1, 32'h9999_9999, 1'b1, 32'h3000_0100, 32'h1111_1111, n, ok);
    tests++;
    if (n !== 1 || !ok) begin
      fails++;
      $display("FAIL b2b_first_burst: got %0d fields_ok=%b want 1 1", n, ok);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus8.rsp_valid_o !== 1'b1 || bus8.rsp_dat_o !== 32'h0 || bus8.rsp_err_o !== 1'b0 ||
          bus8.req_ready_o !== 1'b0 || bus8.wbm_stb_o !== 1'b0)
        hold_ok = 1'b0;
      tick;
    end
    tests++;
    if (!hold_ok) begin
      fails++;
      $display("FAIL b2b_hold: got unstable rsp or ready/stb high want valid=1 dat=0 err=0 ready=0 stb=0");
    end
    handshake;
    tests++;
    if ({bus8.rsp_valid_o, bus8.req_ready_o, bus8.wbm_stb_o} !== 3'b010) begin
      fails++;
      $display("FAIL b2b_idle_cycle: got valid=%b ready=%b stb=%b want 0 1 0",
               bus8.rsp_valid_o, bus8.req_ready_o, bus8.wbm_stb_o);
    end
    tick;
    bus8.req_valid_i = 1'b0;
    tests++;
    if ({bus8.wbm_stb_o, bus8.req_ready_o} !== 2'b10 || bus8.wbm_adr_o !== 32'h3000_0200) begin
      fails++;
      $display("FAIL b2b_accept: got stb=%b ready=%b adr=%h want 1 0 30000200",
               bus8.wbm_stb_o, bus8.req_ready_o, bus8.wbm_adr_o);
    end
    bus_phase(2, 32'h7777_8888, 1'b0, 32'h3000_0200, 32'h2222_2222, n, ok);
    tests++;
    if (n !== 2 || !ok || bus8.rsp_dat_o !== 32'h7777_8888) begin
      fails++;
      $display("FAIL b2b_second: got cycles=%0d fields_ok=%b dat=%h want 2 1 77778888",
               n, ok, bus8.rsp_dat_o);
    end
    handshake;
  endtask

  task automatic test_reset_mid_bus;
    int n;
    bit ok;
    issue_req(1'b0, 32'h3000_0040, 32'h0000_0000);
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus8.wbm_cyc_o, bus8.wbm_stb_o, bus8.rsp_valid_o, bus8.req_ready_o} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_bus: got cyc=%b stb=%b valid=%b ready=%b want 0 0 0 0",
               bus8.wbm_cyc_o, bus8.wbm_stb_o, bus8.rsp_valid_o, bus8.req_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    tick;
    tick;
    tests++;
    if ({bus8.rsp_valid_o, bus8.wbm_stb_o, bus8.req_ready_o} !== 3'b001) begin
      fails++;
      $display("FAIL reset_no_resp: got valid=%b stb=%b ready=%b want 0 0 1",
               bus8.rsp_valid_o, bus8.wbm_stb_o, bus8.req_ready_o);
    end
    issue_req(1'b0, 32'h3000_0044, 32'h0000_0000);
    bus_phase(3, 32'hCAFE_F00D, 1'b0, 32'h3000_0044, 32'h0000_0000, n, ok);
    tests++;
    if (n !== 3 || !ok || bus8.rsp_valid_o !== 1'b1 || bus8.rsp_err_o !== 1'b0 ||
        bus8.rsp_dat_o !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL reset_recover_read: got cycles=%0d ok=%b valid=%b err=%b dat=%h want 3 1 1 0 cafef00d",
               n, ok, bus8.rsp_valid_o, bus8.rsp_err_o, bus8.rsp_dat_o);
    end
    handshake;
  endtask

  task automatic test_expiry_ack;
    int cnt;
    tests++;
    if (bus4.req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL expiry_ready: got %b want 1", bus4.req_ready_o);
    end
    bus4.req_valid_i = 1'b1;
    bus4.req_we_i    = 1'b0;
    bus4.req_adr_i   = 32'h3000_0080;
    tick;
    bus4.req_valid_i = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      if (bus4.wbm_stb_o === 1'b1) cnt++;
      tick;
    end
    if (bus4.wbm_stb_o === 1'b1) cnt++;
    bus4.wbm_ack_i = 1'b1;
    bus4.wbm_dat_i = 32'h0BAD_BEEF;
    tick;
    bus4.wbm_ack_i = 1'b0;
    tests++;
    if (cnt !== 4) begin
      fails++;
      $display("FAIL expiry_stb_cycles: got %0d want 4", cnt);
    end
    tests++;
    if ({bus4.rsp_valid_o, bus4.rsp_err_o, bus4.wbm_stb_o} !== 3'b100 ||
        bus4.rsp_dat_o !== 32'h0BAD_BEEF) begin
      fails++;
      $display("FAIL expiry_ack_wins: got valid=%b err=%b stb=%b dat=%h want 1 0 0 0badbeef",
               bus4.rsp_valid_o, bus4.rsp_err_o, bus4.wbm_stb_o, bus4.rsp_dat_o);
    end
    bus4.rsp_ready_i = 1'b1;
    tick;
    bus4.rsp_ready_i = 1'b0;
    tick;
    // Same instance without ack: expires after exactly four strobe cycles.
    bus4.req_valid_i = 1'b1;
    tick;
    bus4.req_valid_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.wbm_stb_o !== 1'b1) break;
      cnt++;
      tick;
    end
    tests++;
    if (cnt !== 4 || bus4.rsp_err_o !== 1'b1 || bus4.rsp_dat_o !== 32'h0) begin
      fails++;
      $display("FAIL expiry_timeout4: got cycles=%0d err=%b dat=%h want 4 1 00000000",
               cnt, bus4.rsp_err_o, bus4.rsp_dat_o);
    end
    bus4.rsp_ready_i = 1'b1;
    tick;
    bus4.rsp_ready_i = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_back_to_back;
    test_reset_mid_bus;
    test_expiry_ack;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
